// File: rtl/fsm_phase_scan.sv
// fsm_phase_scan: multi-channel trigger-delay sweep across frame-grabber frames, gated by detector readiness
`timescale 1ns/1ps
module fsm_phase_scan #(
  parameter int CHANNELS        = 4,
  parameter int DELAY_WIDTH     = 16,
  parameter int OFFSET_WIDTH    = 8,
  parameter int STEP_WIDTH      = 8,
  parameter int FRAMES_PER_STEP = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                             clock,
  input  logic                             reset_signal,
  input  logic                             start_signal,
  input  logic                             abort_signal,
  input  logic                             fg_signal,
  input  logic                             phase_signal,
  input  logic                             detector_ready,
  input  logic [DELAY_WIDTH-1:0]           delay_start,
  input  logic [DELAY_WIDTH-1:0]           delay_step,
  input  logic [STEP_WIDTH-1:0]            step_count,
  input  logic [CHANNELS-1:0]              channel_mask,
  input  logic [CHANNELS*OFFSET_WIDTH-1:0] channel_offset,
  output logic [CHANNELS-1:0]              output_trigger,
  output logic [7:0]                       scenario_state,
  output logic [STEP_WIDTH-1:0]            counter_out,
  output logic [DELAY_WIDTH-1:0]           current_delay,
  output logic [15:0]                      missed_count,
  output logic                             done
);
  localparam int FW = $clog2(FRAMES_PER_STEP + 1);
  localparam int TW = DELAY_WIDTH + 1;
  typedef enum logic [2:0] {IDLE, WAIT_FG, WAIT_PHASE, DELAY, NEXT, DONE} state_e;
  state_e state_q, state_d;
  logic [SYNC_STAGES-1:0] fg_sync_q, ph_sync_q, rdy_sync_q;
  logic fg_prev_q, ph_prev_q, start_prev_q;
  logic [DELAY_WIDTH-1:0] cur_delay_q, cur_delay_d, step_dly_q, step_dly_d;
  logic [STEP_WIDTH-1:0] step_idx_q, step_idx_d, step_cnt_q, step_cnt_d;
  logic [CHANNELS-1:0] mask_q, mask_d, trig_q, trig_d;
  logic [CHANNELS*OFFSET_WIDTH-1:0] off_q, off_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [15:0] missed_q, missed_d;
  logic [TW-1:0] cnt_q, cnt_d, max_tgt, dly_sum;
  logic [TW-1:0] tgt [CHANNELS];
  logic fg_rise, ph_rise, start_rise, rdy;
  assign fg_rise    = fg_sync_q[SYNC_STAGES-1] & ~fg_prev_q;
  assign ph_rise    = ph_sync_q[SYNC_STAGES-1] & ~ph_prev_q;
  assign rdy        = rdy_sync_q[SYNC_STAGES-1];
  assign start_rise = start_signal & ~start_prev_q;
  assign dly_sum    = {1'b0, cur_delay_q} + {1'b0, step_dly_q};
  // synchronize asynchronous inputs and keep previous values for edge detection
  always_ff @(posedge clock or negedge reset_signal)
    if (!reset_signal) begin
      fg_sync_q    <= '0;
      ph_sync_q    <= '0;
      rdy_sync_q   <= '0;
      fg_prev_q    <= 1'b0;
      ph_prev_q    <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      fg_sync_q    <= {fg_sync_q[SYNC_STAGES-2:0], fg_signal};
      ph_sync_q    <= {ph_sync_q[SYNC_STAGES-2:0], phase_signal};
      rdy_sync_q   <= {rdy_sync_q[SYNC_STAGES-2:0], detector_ready};
      fg_prev_q    <= fg_sync_q[SYNC_STAGES-1];
      ph_prev_q    <= ph_sync_q[SYNC_STAGES-1];
      start_prev_q <= start_signal;
    end
  // per-channel firing counts (one bit wider than the delay, never wraps) and the latest enabled one
  always_comb begin
    max_tgt = {1'b0, cur_delay_q};
    for (int i = 0; i < CHANNELS; i++) begin
      tgt[i] = {1'b0, cur_delay_q} + TW'(off_q[i*OFFSET_WIDTH +: OFFSET_WIDTH]);
      if (mask_q[i] && tgt[i] > max_tgt) max_tgt = tgt[i];
    end
  end
  // next-state, counters and triggers; abort overrides every transition
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_delay_d = cur_delay_q;
    step_dly_d  = step_dly_q;
    step_idx_d  = step_idx_q;
    step_cnt_d  = step_cnt_q;
    mask_d      = mask_q;
    off_d       = off_q;
    frame_d     = frame_q;
    missed_d    = missed_q;
    trig_d      = '0;
    if (abort_signal) state_d = IDLE;
    else case (state_q)
      IDLE, DONE: if (start_rise) begin
        cur_delay_d = delay_start;
        step_dly_d  = delay_step;
        step_cnt_d  = step_count;
        mask_d      = channel_mask;
        off_d       = channel_offset;
        step_idx_d  = '0;
        frame_d     = '0;
        missed_d    = '0;
        state_d     = (step_count == '0) ? DONE : WAIT_FG;
      end
      WAIT_FG: if (fg_rise) state_d = WAIT_PHASE;
      WAIT_PHASE: if (ph_rise) begin
        cnt_d    = '0;
        missed_d = (rdy || &missed_q) ? missed_q : missed_q + 16'd1;
        state_d  = rdy ? DELAY : WAIT_FG;
      end
      DELAY: begin
        cnt_d = cnt_q + TW'(1);
        if (cnt_q == max_tgt) state_d = NEXT;
      end
      NEXT: begin
        frame_d = frame_q + FW'(1);
        if (frame_d == FW'(FRAMES_PER_STEP)) begin
          frame_d     = '0;
          step_idx_d  = step_idx_q + STEP_WIDTH'(1);
          cur_delay_d = dly_sum[DELAY_WIDTH] ? '1 : dly_sum[DELAY_WIDTH-1:0];
        end
        state_d = (step_idx_d == step_cnt_q) ? DONE : WAIT_FG;
      end
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < CHANNELS; i++) trig_d[i] = (state_d == DELAY) && mask_q[i] && (cnt_d == tgt[i]);
  end
  // state, configuration and counter registers
  always_ff @(posedge clock or negedge reset_signal)
    if (!reset_signal) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_delay_q <= '0;
      step_dly_q  <= '0;
      step_idx_q  <= '0;
      step_cnt_q  <= '0;
      mask_q      <= '0;
      off_q       <= '0;
      frame_q     <= '0;
      missed_q    <= '0;
      trig_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_delay_q <= cur_delay_d;
      step_dly_q  <= step_dly_d;
      step_idx_q  <= step_idx_d;
      step_cnt_q  <= step_cnt_d;
      mask_q      <= mask_d;
      off_q       <= off_d;
      frame_q     <= frame_d;
      missed_q    <= missed_d;
      trig_q      <= trig_d;
    end
  assign output_trigger = trig_q;
  assign scenario_state = {5'd0, state_q};
  assign counter_out    = step_idx_q;
  assign current_delay  = cur_delay_q;
  assign missed_count   = missed_q;
  assign done           = (state_q == DONE);
endmodule

// File: tb/tb_fsm_phase_scan.sv
// tb_fsm_phase_scan: directed scenario tests for the phase-scan trigger FSM
`timescale 1ns/1ps
module tb_fsm_phase_scan;
  logic clock = 1'b0, reset_signal = 1'b0, start_signal = 1'b0, abort_signal = 1'b0;
  logic fg_signal = 1'b0, phase_signal = 1'b0, detector_ready = 1'b0;
  logic [15:0] delay_start = '0, delay_step = '0, current_delay, missed_count;
  logic [7:0] step_count = '0, scenario_state, counter_out;
  logic [3:0] channel_mask = '0, output_trigger;
  logic [31:0] channel_offset = '0;
  logic done;
  logic start2 = 1'b0, abort2 = 1'b0, s_mask = 1'b1, s_trig, s_done;
  logic [7:0] s_dstart = '0, s_dstep = '0, s_cnt = '0, s_off = '0, s_state, s_ctr, s_delay;
  logic [15:0] s_missed;
  int checks = 0, failures = 0, cyc = 0, entry_cyc = 0, next_rel = -1;
  int evq[$];
  logic [7:0] prev_st = '0;
  always #5 clock = ~clock;
  fsm_phase_scan dut (
    .clock(clock), .reset_signal(reset_signal), .start_signal(start_signal), .abort_signal(abort_signal),
    .fg_signal(fg_signal), .phase_signal(phase_signal), .detector_ready(detector_ready),
    .delay_start(delay_start), .delay_step(delay_step), .step_count(step_count),
    .channel_mask(channel_mask), .channel_offset(channel_offset), .output_trigger(output_trigger),
    .scenario_state(scenario_state), .counter_out(counter_out), .current_delay(current_delay),
    .missed_count(missed_count), .done(done)
  );
  fsm_phase_scan #(.CHANNELS(1), .DELAY_WIDTH(8), .FRAMES_PER_STEP(1)) u_sat (
    .clock(clock), .reset_signal(reset_signal), .start_signal(start2), .abort_signal(abort2),
    .fg_signal(fg_signal), .phase_signal(phase_signal), .detector_ready(detector_ready),
    .delay_start(s_dstart), .delay_step(s_dstep), .step_count(s_cnt),
    .channel_mask(s_mask), .channel_offset(s_off), .output_trigger(s_trig),
    .scenario_state(s_state), .counter_out(s_ctr), .current_delay(s_delay),
    .missed_count(s_missed), .done(s_done)
  );
  always @(posedge clock) cyc++;
  // trigger recorder: each event is channel*100000 + cycles since DELAY entry
  always @(negedge clock) begin
    if (scenario_state == 8'h03 && prev_st != 8'h03) entry_cyc = cyc;
    if (scenario_state == 8'h04 && prev_st != 8'h04) next_rel = cyc - entry_cyc;
    for (int i = 0; i < 4; i++) if (output_trigger[i]) evq.push_back(i * 100000 + (cyc - entry_cyc));
    prev_st = scenario_state;
  end
  function automatic int ev(input int k);
    return (k < evq.size()) ? evq[k] : -1;
  endfunction
  task automatic cfg(input logic [15:0] ds, input logic [15:0] dp, input logic [7:0] sc, input logic [3:0] m, input logic [31:0] off);
    delay_start = ds; delay_step = dp; step_count = sc; channel_mask = m; channel_offset = off;
  endtask
  task automatic do_start();
    start_signal = 1'b1; @(negedge clock); start_signal = 1'b0;
  endtask
  task automatic do_abort();
    abort_signal = 1'b1; @(negedge clock); abort_signal = 1'b0;
  endtask
  task automatic pulse_fg();
    fg_signal = 1'b1; repeat (4) @(negedge clock); fg_signal = 1'b0;
  endtask
  task automatic wait_settle(input logic sel);
    int n = 0;
    logic [7:0] st;
    st = sel ? s_state : scenario_state;
    while (!(st == 8'h00 || st == 8'h01 || st == 8'h05) && n < 1000) begin
      @(negedge clock); n++; st = sel ? s_state : scenario_state;
    end
    checks++; if (n >= 1000) begin failures++; $display("FAIL settle_timeout got=%0h exp=01/05", st); end
  endtask
  task automatic run_frame(input logic sel, input logic rdy);
    detector_ready = rdy; repeat (4) @(negedge clock);
    pulse_fg();
    phase_signal = 1'b1; repeat (4) @(negedge clock); phase_signal = 1'b0;
    wait_settle(sel);
  endtask
  task automatic test_reset();
    reset_signal = 1'b0; repeat (2) @(negedge clock);
    checks++; if (output_trigger !== 4'h0) begin failures++; $display("FAIL rst_trig got=%0h exp=0", output_trigger); end
    checks++; if (scenario_state !== 8'h00) begin failures++; $display("FAIL rst_state got=%0h exp=0", scenario_state); end
    checks++; if (counter_out !== 8'h00) begin failures++; $display("FAIL rst_counter got=%0h exp=0", counter_out); end
    checks++; if (current_delay !== 16'h0) begin failures++; $display("FAIL rst_delay got=%0h exp=0", current_delay); end
    checks++; if (missed_count !== 16'h0) begin failures++; $display("FAIL rst_missed got=%0h exp=0", missed_count); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0h exp=0", done); end
    reset_signal = 1'b1; @(negedge clock);
  endtask
  task automatic test_reset_mid_delay();
    int n = 0;
    cfg(16'd5, 16'd1, 8'd1, 4'b0011, {8'd0, 8'd0, 8'd10, 8'd0});
    evq.delete(); do_start();
    detector_ready = 1'b1; repeat (4) @(negedge clock);
    pulse_fg();
    phase_signal = 1'b1;
    while (!output_trigger[0] && n < 50) begin @(negedge clock); n++; end
    phase_signal = 1'b0;
    checks++; if (n >= 50) begin failures++; $display("FAIL mid_trig_timeout got=%0h exp=1", output_trigger); end
    #2 reset_signal = 1'b0;
    #1;
    checks++; if (output_trigger !== 4'h0) begin failures++; $display("FAIL mid_rst_trig got=%0h exp=0", output_trigger); end
    checks++; if (scenario_state !== 8'h00) begin failures++; $display("FAIL mid_rst_state got=%0h exp=0", scenario_state); end
    checks++; if (current_delay !== 16'h0) begin failures++; $display("FAIL mid_rst_delay got=%0h exp=0", current_delay); end
    @(negedge clock); reset_signal = 1'b1;
    repeat (30) @(negedge clock);
    checks++; if (evq.size() != 1) begin failures++; $display("FAIL mid_rst_no_pulse got=%0d exp=1", evq.size()); end
  endtask
  task automatic test_basic_scan();
    cfg(16'd10, 16'd5, 8'd3, 4'b0001, 32'h0);
    evq.delete(); do_start();
    checks++; if (scenario_state !== 8'h01) begin failures++; $display("FAIL basic_start_state got=%0h exp=1", scenario_state); end
    checks++; if (current_delay !== 16'd10) begin failures++; $display("FAIL basic_start_delay got=%0d exp=10", current_delay); end
    for (int f = 0; f < 12; f++) run_frame(1'b0, 1'b1);
    checks++; if (evq.size() != 12) begin failures++; $display("FAIL basic_count got=%0d exp=12", evq.size()); end
    for (int k = 0; k < 12; k++) begin
      checks++; if (ev(k) != 10 + 5 * (k / 4)) begin failures++; $display("FAIL basic_rel%0d got=%0d exp=%0d", k, ev(k), 10 + 5 * (k / 4)); end
    end
    checks++; if (counter_out !== 8'd3) begin failures++; $display("FAIL basic_counter got=%0d exp=3", counter_out); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done got=%0h exp=1", done); end
    checks++; if (scenario_state !== 8'h05) begin failures++; $display("FAIL basic_state got=%0h exp=5", scenario_state); end
    checks++; if (current_delay !== 16'd25) begin failures++; $display("FAIL basic_delay got=%0d exp=25", current_delay); end
    repeat (3) @(negedge clock);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done_hold got=%0h exp=1", done); end
  endtask
  task automatic test_channel_skew();
    cfg(16'd20, 16'd1, 8'd1, 4'b1011, {8'd7, 8'd5, 8'd3, 8'd0});
    evq.delete(); do_start();
    detector_ready = 1'b1; repeat (4) @(negedge clock);
    pulse_fg();
    checks++; if (scenario_state !== 8'h02) begin failures++; $display("FAIL skew_fg_state got=%0h exp=2", scenario_state); end
    phase_signal = 1'b1;
    @(negedge clock);
    checks++; if (scenario_state !== 8'h02) begin failures++; $display("FAIL skew_lat1 got=%0h exp=2", scenario_state); end
    @(negedge clock);
    checks++; if (scenario_state !== 8'h02) begin failures++; $display("FAIL skew_lat2 got=%0h exp=2", scenario_state); end
    @(negedge clock);
    checks++; if (scenario_state !== 8'h03) begin failures++; $display("FAIL skew_lat3 got=%0h exp=3", scenario_state); end
    phase_signal = 1'b0;
    wait_settle(1'b0);
    checks++; if (evq.size() != 3) begin failures++; $display("FAIL skew_count got=%0d exp=3", evq.size()); end
    checks++; if (ev(0) != 20) begin failures++; $display("FAIL skew_ch0 got=%0d exp=20", ev(0)); end
    checks++; if (ev(1) != 100023) begin failures++; $display("FAIL skew_ch1 got=%0d exp=100023", ev(1)); end
    checks++; if (ev(2) != 300027) begin failures++; $display("FAIL skew_ch3 got=%0d exp=300027", ev(2)); end
    checks++; if (next_rel != 28) begin failures++; $display("FAIL skew_exit got=%0d exp=28", next_rel); end
    do_abort();
    checks++; if (scenario_state !== 8'h00) begin failures++; $display("FAIL skew_abort got=%0h exp=0", scenario_state); end
  endtask
  task automatic test_detector_gating();
    cfg(16'd2, 16'd1, 8'd1, 4'b0001, 32'h0);
    evq.delete(); do_start();
    run_frame(1'b0, 1'b1);
    run_frame(1'b0, 1'b0);
    run_frame(1'b0, 1'b0);
    checks++; if (missed_count !== 16'd2) begin failures++; $display("FAIL gate_missed got=%0d exp=2", missed_count); end
    checks++; if (evq.size() != 1) begin failures++; $display("FAIL gate_no_trig got=%0d exp=1", evq.size()); end
    for (int f = 0; f < 3; f++) run_frame(1'b0, 1'b1);
    checks++; if (evq.size() != 4) begin failures++; $display("FAIL gate_total got=%0d exp=4", evq.size()); end
    checks++; if (counter_out !== 8'd1) begin failures++; $display("FAIL gate_counter got=%0d exp=1", counter_out); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL gate_done got=%0h exp=1", done); end
    checks++; if (missed_count !== 16'd2) begin failures++; $display("FAIL gate_missed_end got=%0d exp=2", missed_count); end
    checks++; if (current_delay !== 16'd3) begin failures++; $display("FAIL gate_delay got=%0d exp=3", current_delay); end
  endtask
  task automatic test_edge_cases();
    cfg(16'd33, 16'd1, 8'd0, 4'b0001, 32'h0);
    evq.delete(); do_start();
    checks++; if (scenario_state !== 8'h05) begin failures++; $display("FAIL zero_state got=%0h exp=5", scenario_state); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%0h exp=1", done); end
    run_frame(1'b0, 1'b1);
    checks++; if (evq.size() != 0) begin failures++; $display("FAIL zero_trig got=%0d exp=0", evq.size()); end
    cfg(16'd4, 16'd1, 8'd1, 4'b0001, 32'h0);
    evq.delete(); do_start();
    checks++; if (scenario_state !== 8'h01) begin failures++; $display("FAIL restart_state got=%0h exp=1", scenario_state); end
    pulse_fg();
    cfg(16'd99, 16'd1, 8'd1, 4'b0001, 32'h0);
    do_start(); @(negedge clock);
    checks++; if (scenario_state !== 8'h02) begin failures++; $display("FAIL wp_start_state got=%0h exp=2", scenario_state); end
    checks++; if (current_delay !== 16'd4) begin failures++; $display("FAIL wp_start_delay got=%0d exp=4", current_delay); end
    phase_signal = 1'b1; repeat (4) @(negedge clock); phase_signal = 1'b0;
    wait_settle(1'b0);
    checks++; if (ev(0) != 4 || evq.size() != 1) begin failures++; $display("FAIL wp_trig got=%0d n=%0d exp=4 n=1", ev(0), evq.size()); end
    do_abort();
  endtask
  task automatic test_abort();
    cfg(16'd20, 16'd1, 8'd2, 4'b0001, 32'h0);
    evq.delete(); do_start();
    pulse_fg();
    phase_signal = 1'b1; repeat (6) @(negedge clock); phase_signal = 1'b0;
    checks++; if (scenario_state !== 8'h03) begin failures++; $display("FAIL abort_in_delay got=%0h exp=3", scenario_state); end
    do_abort();
    checks++; if (scenario_state !== 8'h00) begin failures++; $display("FAIL abort_state got=%0h exp=0", scenario_state); end
    checks++; if (current_delay !== 16'd20) begin failures++; $display("FAIL abort_hold got=%0d exp=20", current_delay); end
    repeat (30) @(negedge clock);
    checks++; if (evq.size() != 0) begin failures++; $display("FAIL abort_no_trig got=%0d exp=0", evq.size()); end
    cfg(16'd7, 16'd1, 8'd2, 4'b0001, 32'h0);
    do_start();
    checks++; if (current_delay !== 16'd7) begin failures++; $display("FAIL abort_restart_delay got=%0d exp=7", current_delay); end
    checks++; if (scenario_state !== 8'h01) begin failures++; $display("FAIL abort_restart_state got=%0h exp=1", scenario_state); end
    run_frame(1'b0, 1'b1);
    checks++; if (ev(0) != 7 || evq.size() != 1) begin failures++; $display("FAIL abort_restart_trig got=%0d n=%0d exp=7 n=1", ev(0), evq.size()); end
    do_abort();
  endtask
  task automatic test_saturation();
    s_dstart = 8'hFE; s_dstep = 8'd4; s_cnt = 8'd3;
    start2 = 1'b1; @(negedge clock); start2 = 1'b0;
    checks++; if (s_delay !== 8'hFE) begin failures++; $display("FAIL sat_start got=%0h exp=fe", s_delay); end
    for (int k = 0; k < 3; k++) begin
      run_frame(1'b1, 1'b1);
      checks++; if (s_ctr !== 8'(k + 1)) begin failures++; $display("FAIL sat_ctr%0d got=%0d exp=%0d", k, s_ctr, k + 1); end
      checks++; if (s_delay !== 8'hFF) begin failures++; $display("FAIL sat_delay%0d got=%0h exp=ff", k, s_delay); end
    end
    checks++; if (s_done !== 1'b1) begin failures++; $display("FAIL sat_done got=%0h exp=1", s_done); end
  endtask
  initial begin
    test_reset();
    test_reset_mid_delay();
    test_basic_scan();
    test_channel_skew();
    test_detector_gating();
    test_edge_cases();
    test_abort();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
